// File: rtl/ram_char_writer.sv
// ram_char_writer
//   Write-side front end of the character RAM feeding the display line.
//   Accepts one ASCII byte per valid/ready handshake, keeps a cursor and
//   turns printable characters, backspace, carriage return and form feed
//   into single-cycle RAM write strobes. After reset (and on form feed) the
//   whole line is swept with BLANK so the read side always finds a clean line.
//
// Parameters
//   LEN    number of character cells, addresses 0..LEN-1 (1..255)
//   BLANK  fill byte used by the clear sweep and by backspace
//
// Ports
//   wrclock     in   single clock, also the RAM write clock
//   reset       in   synchronous active-high reset
//   char_in     in   [7:0] ASCII byte offered by the source
//   char_valid  in   char_in is valid
//   char_ready  out  a byte can be accepted this cycle
//   data        out  [7:0] RAM write data
//   wraddress   out  [7:0] RAM write address
//   wren        out  RAM write enable, one-cycle strobe per write
//   cursor      out  [7:0] next write position, 0..LEN
//   busy        out  high while a clear sweep runs
//
// Build option
//   RAM_CHAR_WRITER_WRAP_EN  defined: cursor wraps to 0 after writing cell
//                            LEN-1. Undefined: cursor saturates at LEN and
//                            further printable bytes are dropped.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | sweeping BLANK over cells 0..LEN-1, one write per cycle
// S_IDLE  | char_ready high, classifying accepted bytes
// S_WRITE | one-cycle write strobe for a printable byte or backspace

module ram_char_writer #(
  parameter int unsigned LEN   = 11,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       wrclock,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [7:0] data,
  output logic [7:0] wraddress,
  output logic       wren,
  output logic [7:0] cursor,
  output logic       busy
);

  localparam logic [7:0] LEN_B = 8'(LEN);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_FF = 8'h0C;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_WRITE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] cursor_d;
  logic [7:0] data_d;
  logic [7:0] wraddress_d;
  logic       wren_d;
  logic       char_ready_d;
  logic       busy_d;

  logic       accept;
  logic       is_print;

  assign accept   = char_valid & char_ready;
  assign is_print = (char_in >= 8'h20) && (char_in <= 8'h7E);

  always_ff @(posedge wrclock) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      idx_q      <= 8'd0;
      cursor     <= 8'd0;
      data       <= 8'd0;
      wraddress  <= 8'd0;
      wren       <= 1'b0;
      char_ready <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cursor     <= cursor_d;
      data       <= data_d;
      wraddress  <= wraddress_d;
      wren       <= wren_d;
      char_ready <= char_ready_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cursor_d     = cursor;
    data_d       = data;
    wraddress_d  = wraddress;
    wren_d       = 1'b0;
    char_ready_d = char_ready;
    busy_d       = busy;

    case (state_q)
      S_CLEAR: begin
        // idx_q == LEN means every cell has been driven; this extra cycle
        // lets the last strobe retire before char_ready goes high.
        if (idx_q == LEN_B) begin
          state_d      = S_IDLE;
          char_ready_d = 1'b1;
          busy_d       = 1'b0;
        end else begin
          wren_d       = 1'b1;
          data_d       = BLANK;
          wraddress_d  = idx_q;
          idx_d        = idx_q + 8'd1;
          char_ready_d = 1'b0;
          busy_d       = 1'b1;
        end
      end

      S_IDLE: begin
        char_ready_d = 1'b1;
        busy_d       = 1'b0;
        if (accept) begin
          if (is_print) begin
            if (cursor < LEN_B) begin
              state_d      = S_WRITE;
              wren_d       = 1'b1;
              data_d       = char_in;
              wraddress_d  = cursor;
              char_ready_d = 1'b0;
`ifdef RAM_CHAR_WRITER_WRAP_EN
              cursor_d     = (cursor == LEN_B - 8'd1) ? 8'd0 : cursor + 8'd1;
`else
              cursor_d     = cursor + 8'd1;
`endif
            end
          end else if (char_in == CH_BS) begin
            if (cursor != 8'd0) begin
              state_d      = S_WRITE;
              wren_d       = 1'b1;
              data_d       = BLANK;
              wraddress_d  = cursor - 8'd1;
              cursor_d     = cursor - 8'd1;
              char_ready_d = 1'b0;
            end
          end else if (char_in == CH_CR) begin
            cursor_d = 8'd0;
          end else if (char_in == CH_FF) begin
            // Cell 0 is driven on the accept edge itself so the sweep
            // occupies the very next cycle.
            state_d      = S_CLEAR;
            wren_d       = 1'b1;
            data_d       = BLANK;
            wraddress_d  = 8'd0;
            idx_d        = 8'd1;
            cursor_d     = 8'd0;
            char_ready_d = 1'b0;
            busy_d       = 1'b1;
          end
        end
      end

      S_WRITE: begin
        state_d      = S_IDLE;
        char_ready_d = 1'b1;
        busy_d       = 1'b0;
      end

      default: begin
        state_d = S_CLEAR;
        idx_d   = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_char_writer.sv
module tb_ram_char_writer;

  localparam int unsigned LEN   = 11;
  localparam logic [7:0]  BLANK = 8'h20;

  logic       wrclock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [7:0] data;
  logic [7:0] wraddress;
  logic       wren;
  logic [7:0] cursor;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: line contents and cursor
  logic [7:0] mem_ref [LEN];
  int         cur_ref;
  // image of what the DUT actually wrote
  logic [7:0] mem_dut [LEN];

  ram_char_writer #(.LEN(LEN), .BLANK(BLANK)) dut (
    .wrclock    (wrclock),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .data       (data),
    .wraddress  (wraddress),
    .wren       (wren),
    .cursor     (cursor),
    .busy       (busy)
  );

  always #5 wrclock = ~wrclock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // every write strobe must land inside the line
  always @(negedge wrclock) begin
    if (wren === 1'b1) begin
      chk("addr_range", 32'(wraddress < 8'(LEN)), 32'd1);
      if (wraddress < 8'(LEN)) mem_dut[wraddress] = data;
    end
  end

  task automatic model_clear();
    for (int i = 0; i < LEN; i++) mem_ref[i] = BLANK;
    cur_ref = 0;
  endtask

  // entered just after the edge that registers the first sweep write;
  // leaves positioned at a falling edge
  task automatic check_sweep(input string tag);
    for (int k = 0; k < LEN; k++) begin
      @(negedge wrclock);
      chk({tag, "_wren"}, wren, 1);
      chk({tag, "_addr"}, wraddress, k);
      chk({tag, "_data"}, data, BLANK);
      chk({tag, "_rdy"}, char_ready, 0);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_cur"}, cursor, 0);
    end
    @(negedge wrclock);
    chk({tag, "_end_wren"}, wren, 0);
    chk({tag, "_end_rdy"}, char_ready, 1);
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_cur"}, cursor, 0);
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    char_valid = 1'b0;
    repeat (ncyc) @(posedge wrclock);
    @(negedge wrclock);
    chk("rst_wren", wren, 0);
    chk("rst_data", data, 0);
    chk("rst_addr", wraddress, 0);
    chk("rst_cur", cursor, 0);
    chk("rst_rdy", char_ready, 0);
    chk("rst_busy", busy, 1);
    reset = 1'b0;
    @(posedge wrclock);
    model_clear();
    check_sweep("rst_sweep");
  endtask

  // called at a falling edge; returns 1 ns after the accept edge
  task automatic accept(input logic [7:0] b, output bit ok);
    int n;
    char_in = b;
    char_valid = 1'b1;
    n = 0;
    while (char_ready !== 1'b1 && n < 100) begin
      @(negedge wrclock);
      n++;
    end
    ok = (char_ready === 1'b1);
    if (!ok) begin
      chk("ready_timeout", char_ready, 1);
      char_valid = 1'b0;
      return;
    end
    @(posedge wrclock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit         ok;
    bit         exp_wr;
    bit         ff;
    logic [7:0] ea;
    logic [7:0] ed;
    exp_wr = 0;
    ff = 0;
    ea = 0;
    ed = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (cur_ref < LEN) begin
        exp_wr = 1; ea = 8'(cur_ref); ed = b;
`ifdef RAM_CHAR_WRITER_WRAP_EN
        cur_ref = (cur_ref + 1) % LEN;
`else
        cur_ref = cur_ref + 1;
`endif
      end
    end else if (b == 8'h08) begin
      if (cur_ref > 0) begin
        cur_ref = cur_ref - 1;
        exp_wr = 1; ea = 8'(cur_ref); ed = BLANK;
      end
    end else if (b == 8'h0D) begin
      cur_ref = 0;
    end else if (b == 8'h0C) begin
      ff = 1;
    end

    accept(b, ok);
    if (!ok) return;

    if (ff) begin
      char_valid = 1'b0;
      model_clear();
      check_sweep("ff_sweep");
    end else if (exp_wr) begin
      mem_ref[ea] = ed;
      @(negedge wrclock);
      chk("wr_wren", wren, 1);
      chk("wr_addr", wraddress, ea);
      chk("wr_data", data, ed);
      chk("wr_cur", cursor, cur_ref);
      chk("wr_rdy", char_ready, 0);
      // valid still high across a not-ready edge: must not re-accept
      @(negedge wrclock);
      chk("wr_after_wren", wren, 0);
      chk("wr_after_rdy", char_ready, 1);
      chk("wr_after_cur", cursor, cur_ref);
      char_valid = 1'b0;
    end else begin
      @(negedge wrclock);
      char_valid = 1'b0;
      chk("nw_wren", wren, 0);
      chk("nw_cur", cursor, cur_ref);
      chk("nw_rdy", char_ready, 1);
      chk("nw_busy", busy, 0);
    end
  endtask

  initial begin
    bit         ok;
    int         r;
    logic [7:0] b;

    for (int i = 0; i < LEN; i++) mem_dut[i] = 8'hxx;
    model_clear();
    @(negedge wrclock);
    do_reset(2);

    // "HI", backspace, backspace to the start, backspace at 0, CR
    send(8'h48);
    send(8'h49);
    chk("hi_cur", cursor, 2);
    send(8'h08);
    send(8'h08);
    send(8'h08);
    send(8'h0D);

    // overrun the line
    for (int i = 0; i < 12; i++) send(8'(8'h41 + i));
`ifdef RAM_CHAR_WRITER_WRAP_EN
    chk("over_cur", cursor, 1);
`else
    chk("over_cur", cursor, LEN);
`endif
    send(8'h08);

    // form feed mid-line, then CR
    send(8'h0D);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    chk("ff_pre_cur", cursor, 5);
    send(8'h0C);
    send(8'h0D);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      b = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 73) b = 8'h08;
      else if (r < 80) b = 8'h0D;
      else if (r < 83) b = 8'h0C;
      else             b = 8'($urandom_range(0, 255));
      send(b);
    end

    for (int i = 0; i < LEN; i++) chk("mem_cell", mem_dut[i], mem_ref[i]);

    // reset in the middle of a clear sweep
    send(8'h58);
    send(8'h59);
    accept(8'h0C, ok);
    char_valid = 1'b0;
    if (ok) begin
      for (int k = 0; k < 6; k++) begin
        @(negedge wrclock);
        chk("abort_addr", wraddress, k);
        chk("abort_wren", wren, 1);
      end
    end else begin
      @(negedge wrclock);
    end
    do_reset(1);
    send(8'h5A);
    chk("final_cur", cursor, cur_ref);
    for (int i = 0; i < LEN; i++) chk("mem_final", mem_dut[i], mem_ref[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_char_writer.md
# ram_char_writer

Write-side front end of the 8-bit character RAM that feeds the 11-character display line. Accepts one ASCII byte at a time over a valid/ready handshake and keeps a cursor. Turns printable characters, backspace, carriage return and form feed into single-cycle RAM write strobes (`data`, `wraddress`, `wren`) on `wrclock`, so the read-side stage always finds a blank-filled, cursor-consistent line.

## Interface
- `LEN`, 11, number of character cells (addresses 0..LEN-1); legal range 1..255
- `BLANK`, 8'h20, fill byte used by clear and backspace

Ports:
- `wrclock`  in  1  single clock; also the RAM write clock
- `reset`  in  1  reset, synchronous and active-high, sampled on rising `wrclock`
- `char_in`  in  8  ASCII byte offered by the source
- `char_valid`  in  1  `char_in` is valid
- `char_ready`  out  1  block can accept a byte this cycle
- `data`  out  8  RAM write data
- `wraddress`  out  8  RAM write address
- `wren`  out  1  RAM write enable, one-cycle strobe per write
- `cursor`  out  8  next write position, 0..LEN
- `busy`  out  1  high while a clear sweep runs

## Operation
- All outputs are registered. States: CLEAR, IDLE, WRITE.
- Reset values: `wren`=0, `data`=0, `wraddress`=0, `cursor`=0, `char_ready`=0, `busy`=1. The state is CLEAR with sweep index 0.
- CLEAR:
  - Each cycle drives `wren`=1, `data`=BLANK and `wraddress`=index, then increments index.
  - After index LEN-1 is driven, the block goes to IDLE.
  - On entry, `cursor` is set to 0. `char_ready`=0 throughout.
- IDLE:
  - `char_ready`=1 and `wren`=0.
  - A byte is accepted when `char_valid` and `char_ready` are both high on a rising edge. It is classified as follows:
  - 0x20..0x7E (printable):
    - If `cursor`<LEN, go to WRITE with `data`=byte and `wraddress`=`cursor`, and increment `cursor`.
    - If `cursor`==LEN, see Configuration.
  - 0x08 (backspace):
    - If `cursor`>0, decrement `cursor`, then go to WRITE with `data`=BLANK and `wraddress`=new cursor.
    - If `cursor`==0, the byte is consumed and nothing changes.
  - 0x0D (carriage return): `cursor` becomes 0; no write; stay in IDLE.
  - 0x0C (form feed): go to CLEAR with index 0.
  - Any other byte: consumed and ignored; stay in IDLE.
- WRITE: `wren`=1 for exactly one cycle, `char_ready`=0, then return to IDLE.
- Address width rule: `cursor` and index are 8-bit and zero-extend onto `wraddress`. No address ≥ LEN is ever driven.

## Timing
- Reset deasserted at edge R: `wren`=1 with `wraddress`=0 in cycle R+1, through `wraddress`=LEN-1 in cycle R+LEN. In cycle R+LEN+1, `char_ready`=1 and `busy`=0.
- Accept at edge N: cycle N+1 holds `wren`=1 with the new `data`/`wraddress`, and `cursor` already updated. The RAM captures at edge N+1. `char_ready` returns to 1 in cycle N+2.
- Peak throughput is 1 write per 2 cycles. Ignored bytes and CR cost 1 cycle, and `char_ready` stays high.
- `char_valid` held high with `char_ready` low is not an accept. The source must hold its byte until accepted.
- Reset asserted mid-CLEAR or mid-WRITE aborts the operation at that edge and restarts the full sweep. A byte in flight is lost.
- Form feed mid-line: the sweep starts the cycle after acceptance, and LEN+1 cycles pass until `char_ready`=1.

## Configuration
- `RAM_CHAR_WRITER_WRAP_EN` defined:
  - A printable byte written at cursor LEN-1 sets `cursor` to 0, so `cursor` never reaches LEN.
  - The next printable byte overwrites address 0.
- Not defined:
  - `cursor` saturates at LEN.
  - Printable bytes accepted at LEN are consumed with no write and no `wren`.
  - Backspace at LEN blanks address LEN-1.

## Test plan
- Reset for 2 cycles, then release → 11 consecutive `wren` pulses with `data`=0x20 and addresses 0..10. `char_ready` rises in cycle 12; `cursor`=0.
- Send 0x48 then 0x49 with `char_valid` held high → writes (0,0x48) and (1,0x49), each `wren` one cycle apart by 2 cycles; `cursor`=2.
- After "HI", send 0x08 → write (1,0x20) and `cursor`=1. At `cursor`=0, send 0x08 → no `wren`, `cursor` stays 0.
- Send 12 printable bytes 0x41..0x4C:
  - Macro off: 11 writes to addresses 0..10, 12th byte dropped, `cursor`=10 after the 10th… then 11.
  - Macro on: 12th byte writes (0,0x4C) and `cursor`=1.
- Send 0x0C with `cursor`=5 → 11-cycle blank sweep, `cursor`=0. Then send 0x0D → no write, `cursor`=0.
- Assert reset during the sweep at index 6 → sweep restarts at address 0 after release; no address ≥11 is ever driven (assertion over the whole run).
